hack_mem_arbiter: RTL and testbench

Shares the single data-RAM port between the Hack CPU (addressM/writeM/outM/inM) and a burst DMA engine used for screen and bulk copies. The CPU normally owns the port; DMA words are transferred in cycles where the CPU does not touch M. An optional starvation guard stalls the CPU for one cycle to force a DMA slot. The block sits between the CPU, the DMA client and an asynchronous-read, clocked-write RAM.

---
 rtl/hack_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_hack_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_mem_arbiter.sv
// Arbitrates the single data-RAM port between the Hack CPU and a burst DMA engine.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module hack_mem_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_busy,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_we;
    logic              w_dma_gnt;
    logic              w_force;

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

`ifdef ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] r_wait;

    // A forced slot clears the counter, so it can never fire on two consecutive cycles.
    assign w_force = (r_state == S_BURST) && cpu_req && (r_wait == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if ((r_state != S_BURST) || w_dma_gnt) begin
            r_wait <= '0;
        end else if (cpu_req) begin
            r_wait <= r_wait + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    assign w_dma_gnt = (r_state == S_BURST) && (!cpu_req || w_force);
    assign cpu_stall = w_force;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_we   <= 1'b0;
        end else if ((r_state == S_IDLE) && dma_start) begin
            r_addr <= dma_base;
            r_rem  <= dma_len;
            r_we   <= dma_we;
        end else if (w_dma_gnt) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_addr    = cpu_addr;
        mem_we      = cpu_we & cpu_req;
        mem_wdata   = cpu_wdata;
        dma_ack     = 1'b0;
        dma_done    = 1'b0;
        dma_busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (dma_start) begin
                    w_state_nxt = (dma_len == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (w_dma_gnt) begin
                    mem_addr  = r_addr;
                    mem_we    = r_we;
                    mem_wdata = dma_wdata;
                    dma_ack   = 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                dma_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Keep the RAM untouched while reset is held, even if the CPU drives a write.
        if (!reset_n) begin
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural async-read/clocked-write RAM.
module tb_hack_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_start;
    logic [14:0] dma_base;
    logic [7:0]  dma_len;
    logic        dma_we;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic        dma_busy;
    logic        dma_done;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:32767];
    int          n_chk;
    int          n_err;

    hack_mem_arbiter #(
        .ADDR_W(15), .DATA_W(16), .LEN_W(8), .MAX_WAIT(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
        .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .dma_busy(dma_busy), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic start_burst(input logic [14:0] b, input logic [7:0] l, input logic w);
        dma_base = b; dma_len = l; dma_we = w; dma_start = 1'b1;
        tick();
        dma_start = 1'b0; dma_base = '0; dma_len = '0;
    endtask

    logic [15:0] rd_exp [4];
    logic        fz;

    initial begin
        n_chk = 0; n_err = 0;
        reset_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5;
        cpu_wdata = 16'hFFFF; dma_start = 1'b0; dma_base = '0; dma_len = '0;
        dma_we = 1'b0; dma_wdata = '0;
        rd_exp[0] = 16'h1234; rd_exp[1] = 16'h2345; rd_exp[2] = 16'h3456; rd_exp[3] = 16'h4567;

        // Reset state with a CPU write being presented
        tick(); tick(); #2;
        chk("rst_busy", 32'(dma_busy), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_ack", 32'(dma_ack), 0);
        chk("rst_done", 32'(dma_done), 0);
        reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        tick();

        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd1000; cpu_wdata = 16'h1234; #2;
        chk("idle_cpu_we", 32'(mem_we), 1);
        chk("idle_cpu_addr", 32'(mem_addr), 1000);
        tick(); cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_write(15'd1001, 16'h2345);
        cpu_write(15'd1002, 16'h3456);
        cpu_write(15'd1003, 16'h4567);

        // Read burst 1000..1003, CPU idle
        start_burst(15'd1000, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rd_ack", 32'(dma_ack), 1);
            chk("rd_busy", 32'(dma_busy), 1);
            chk("rd_addr", 32'(mem_addr), 1000 + i);
            chk("rd_data", 32'(dma_rdata), 32'(rd_exp[i]));
            chk("rd_done_early", 32'(dma_done), 0);
            tick();
        end
        #2;
        chk("rd_done", 32'(dma_done), 1);
        chk("rd_done_ack", 32'(dma_ack), 0);
        chk("rd_done_busy", 32'(dma_busy), 1);
        tick(); #2;
        chk("rd_after_done", 32'(dma_done), 0);
        chk("rd_after_busy", 32'(dma_busy), 0);
        tick();

        // Write burst wrapping at the top of the address space
        start_burst(15'd32767, 8'd2, 1'b1);
        dma_wdata = 16'h1111; #2;
        chk("wr0_ack", 32'(dma_ack), 1);
        chk("wr0_addr", 32'(mem_addr), 32767);
        chk("wr0_we", 32'(mem_we), 1);
        chk("wr0_wdata", 32'(mem_wdata), 32'h1111);
        tick();
        dma_wdata = 16'h2222; #2;
        chk("wr1_ack", 32'(dma_ack), 1);
        chk("wr1_addr_wrap", 32'(mem_addr), 0);
        tick(); #2;
        chk("wr_done", 32'(dma_done), 1);
        chk("wr_done_we", 32'(mem_we), 0);
        tick(); #2;
        chk("wr_done_once", 32'(dma_done), 0);
        chk("ram_32767", 32'(ram[32767]), 32'h1111);
        chk("ram_0", 32'(ram[0]), 32'h2222);

        // CPU contention: alternating CPU writes to 14 and DMA writes to 300/301
        start_burst(15'd300, 8'd2, 1'b1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd14; cpu_wdata = 16'hC0DE; dma_wdata = 16'hDEAD; #2;
        chk("ct1_ack", 32'(dma_ack), 0);
        chk("ct1_addr", 32'(mem_addr), 14);
        chk("ct1_we", 32'(mem_we), 1);
        chk("ct1_stall", 32'(cpu_stall), 0);
        tick();
        cpu_req = 1'b0; dma_wdata = 16'h3000; #2;
        chk("ct2_ack", 32'(dma_ack), 1);
        chk("ct2_addr", 32'(mem_addr), 300);
        tick();
        cpu_req = 1'b1; cpu_wdata = 16'hBEEF; dma_wdata = 16'hDEAD; #2;
        chk("ct3_ack", 32'(dma_ack), 0);
        chk("ct3_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        cpu_req = 1'b0; dma_wdata = 16'h3001; #2;
        chk("ct4_ack", 32'(dma_ack), 1);
        chk("ct4_addr", 32'(mem_addr), 301);
        tick();
        cpu_we = 1'b0; #2;
        chk("ct_done", 32'(dma_done), 1);
        tick();
        chk("ram_14", 32'(ram[14]), 32'hBEEF);
        chk("ram_300", 32'(ram[300]), 32'h3000);
        chk("ram_301", 32'(ram[301]), 32'h3001);

        // CPU hogging the port during a 2-word read burst
        cpu_write(15'd400, 16'hAAAA);
        cpu_write(15'd401, 16'hBBBB);
        start_burst(15'd400, 8'd2, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd20; cpu_wdata = 16'h7777;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 18; i++) begin
            #2;
            fz = (i == 9) || (i == 18);
            chk("gd_ack", 32'(dma_ack), fz ? 1 : 0);
            chk("gd_stall", 32'(cpu_stall), fz ? 1 : 0);
            chk("gd_mem_we", 32'(mem_we), fz ? 0 : 1);
            if (fz) chk("gd_rdata", 32'(dma_rdata), (i == 9) ? 32'hAAAA : 32'hBBBB);
            tick();
        end
        #2;
        chk("gd_done", 32'(dma_done), 1);
        chk("gd_done_stall", 32'(cpu_stall), 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
`else
        for (int i = 1; i <= 20; i++) begin
            #2;
            chk("ng_ack", 32'(dma_ack), 0);
            chk("ng_stall", 32'(cpu_stall), 0);
            chk("ng_busy", 32'(dma_busy), 1);
            tick();
        end
        cpu_req = 1'b0; cpu_we = 1'b0; #2;
        chk("ng_ack0", 32'(dma_ack), 1);
        chk("ng_rdata0", 32'(dma_rdata), 32'hAAAA);
        tick(); #2;
        chk("ng_ack1", 32'(dma_ack), 1);
        chk("ng_rdata1", 32'(dma_rdata), 32'hBBBB);
        tick(); #2;
        chk("ng_done", 32'(dma_done), 1);
        tick();
`endif
        chk("ram_20", 32'(ram[20]), 32'h7777);

        // Empty burst
        start_burst(15'd900, 8'd0, 1'b1);
        #2;
        chk("e_done", 32'(dma_done), 1);
        chk("e_ack", 32'(dma_ack), 0);
        chk("e_we", 32'(mem_we), 0);
        chk("e_busy", 32'(dma_busy), 1);
        tick(); #2;
        chk("e_done_once", 32'(dma_done), 0);
        chk("e_busy_off", 32'(dma_busy), 0);
        tick();

        // Start pulses in BURST and DONE are ignored
        start_burst(15'd500, 8'd3, 1'b0);
        dma_base = 15'd600; dma_len = 8'd1; dma_start = 1'b1; #2;
        chk("ig_addr0", 32'(mem_addr), 500);
        tick();
        dma_start = 1'b0; #2;
        chk("ig_addr1", 32'(mem_addr), 501);
        tick(); #2;
        chk("ig_addr2", 32'(mem_addr), 502);
        chk("ig_ack2", 32'(dma_ack), 1);
        tick();
        dma_start = 1'b1; #2;
        chk("ig_done", 32'(dma_done), 1);
        tick();
        dma_start = 1'b0; #2;
        chk("ig_idle", 32'(dma_busy), 0);
        tick();

        // Reset in the middle of a burst
        start_burst(15'd700, 8'd5, 1'b0);
        #2; chk("mr_ack0", 32'(dma_ack), 1);
        tick();
        #2; chk("mr_addr1", 32'(mem_addr), 701);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd30; reset_n = 1'b0; #1;
        chk("mr_busy", 32'(dma_busy), 0);
        chk("mr_ack", 32'(dma_ack), 0);
        chk("mr_we", 32'(mem_we), 0);
        chk("mr_stall", 32'(cpu_stall), 0);
        chk("mr_done", 32'(dma_done), 0);
        tick(); #2;
        chk("mr_done_hold", 32'(dma_done), 0);
        tick();
        reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; #2;
        chk("mr_rel_done", 32'(dma_done), 0);
        chk("mr_rel_busy", 32'(dma_busy), 0);
        tick();
        start_burst(15'd800, 8'd1, 1'b1);
        dma_wdata = 16'h8888; #2;
        chk("mr_new_ack", 32'(dma_ack), 1);
        chk("mr_new_addr", 32'(mem_addr), 800);
        tick(); #2;
        chk("mr_new_done", 32'(dma_done), 1);
        tick(); #2;
        chk("mr_new_idle", 32'(dma_busy), 0);
        chk("ram_800", 32'(ram[800]), 32'h8888);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
